interleaver_seq: RTL and testbench

Sequenced, parametrised successor to the combinational interleaver set. It owns its cycle counter and holds the sweep-start table in flops, reset-initialised from a parameter. It streams one registered package of Z activation-memory addresses per cycle over a valid/ready handshake, and sits between the junction controller and the left-hand activation memories.

---
 rtl/interleaver_seq.sv | 161 ++++++++++++++++
 tb/tb_interleaver_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_seq.sv
`timescale 1ns/1ps
// interleaver_seq: sequenced interleaver. Each cycle it produces a registered
// package of Z activation-memory addresses on a valid/ready handshake.
// The sweep-start table is held in flops and reset to SEED.
// Optional feature macro: INTLV_SEED_LOAD_EN adds a load port that rewrites
// one table row per transfer while the block is idle.
//
// Handshake: a package moves from producer to consumer on a rising edge where
// out_valid && out_ready. While out_valid is high and out_ready is low, the
// package, out_cycle, out_last and the cycle counter are all held. The load
// port follows the same rule with ld_valid/ld_ready.
module interleaver_seq #(
  parameter int P  = 32,
  parameter int FO = 2,
  parameter int Z  = 8,
  parameter logic [FO*Z*((P == Z) ? 1 : $clog2(P / Z))-1:0] SEED = '0,
  localparam int LOG_P    = $clog2(P),
  localparam int LOG_PBYZ = (P == Z) ? 1 : $clog2(P / Z),
  localparam int CPC      = P * FO / Z,
  localparam int CW       = $clog2(CPC),
  localparam int RW       = (FO == 1) ? 1 : $clog2(FO)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LOG_P*Z-1:0]   mem_index_pkg,
  output logic [CW-1:0]        out_cycle,
  output logic                 out_last,
`ifdef INTLV_SEED_LOAD_EN
  input  logic                 ld_valid,
  input  logic [RW-1:0]        ld_row,
  input  logic [Z*LOG_PBYZ-1:0] ld_data,
  output logic                 ld_ready,
`endif
  output logic                 busy
);

  localparam int TW = FO * Z * LOG_PBYZ;

  typedef enum logic {IDLE, RUN} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         c_q, c_d;
  logic                  out_valid_q, out_valid_d;
  logic [LOG_P*Z-1:0]    pkg_q, pkg_d;
  logic [CW-1:0]         cycle_q, cycle_d;
  logic                  last_q, last_d;

  logic [TW-1:0]         tbl;
  logic [RW-1:0]         row;
  logic [LOG_PBYZ-1:0]   sweep_ofs;
  logic [LOG_PBYZ-1:0]   sweep;
  logic [LOG_P*Z-1:0]    pkg_next;

`ifdef INTLV_SEED_LOAD_EN
  logic [TW-1:0] tbl_q, tbl_d;

  assign tbl      = tbl_q;
  assign ld_ready = (state_q == IDLE);

  // Row write from the load port; only accepted while idle.
  always_comb begin
    tbl_d = tbl_q;
    if (ld_valid && ld_ready && (int'(ld_row) < FO)) begin
      tbl_d[int'(ld_row)*Z*LOG_PBYZ +: Z*LOG_PBYZ] = ld_data;
    end
  end

  // Table flops, restored to SEED on reset.
  always_ff @(posedge clk) begin
    if (reset) tbl_q <= SEED;
    else       tbl_q <= tbl_d;
  end
`else
  assign tbl = SEED;
`endif

  // Counter split: upper bits pick the table row, lower bits are the sweep
  // offset i/Z (wt mod P only depends on c mod P/Z since Z divides P).
  assign row       = RW'(c_q >> LOG_PBYZ);
  assign sweep_ofs = c_q[LOG_PBYZ-1:0];

  // Address package for the current counter value; the LOG_PBYZ-bit sum wraps
  // naturally, which is the mod P/Z. Lane k always keeps k as its low part.
  always_comb begin
    pkg_next = '0;
    sweep    = '0;
    for (int k = 0; k < Z; k++) begin
      if (P == Z) begin
        pkg_next[LOG_P*k +: LOG_P] = LOG_P'(k);
      end else begin
        sweep = tbl[(int'(row)*Z + k)*LOG_PBYZ +: LOG_PBYZ] + sweep_ofs;
        pkg_next[LOG_P*k +: LOG_P] = LOG_P'(int'(sweep) * Z + k);
      end
    end
  end

  // Next-state logic for the sequencer and its registered outputs.
  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    pkg_d       = pkg_q;
    cycle_d     = cycle_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        // A package left over from the last pass drains here.
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
          c_d     = '0;
        end
      end
      RUN: begin
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          pkg_d       = pkg_next;
          cycle_d     = c_q;
          last_d      = (c_q == CW'(CPC - 1));
          if (c_q == CW'(CPC - 1)) begin
            c_d = '0;
            if (!continuous) state_d = IDLE;
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any pending package.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      pkg_q       <= '0;
      cycle_q     <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      pkg_q       <= pkg_d;
      cycle_q     <= cycle_d;
      last_q      <= last_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign mem_index_pkg = pkg_q;
  assign out_cycle     = cycle_q;
  assign out_last      = last_q;
  assign busy          = (state_q == RUN);

endmodule

// File: tb/tb_interleaver_seq.sv
`timescale 1ns/1ps
// Bench for interleaver_seq at P=4, FO=2, Z=2. Two instances: dut 0 uses
// SEED=4'b0110, dut 1 uses SEED=0 (and carries the load port when
// INTLV_SEED_LOAD_EN is defined).
module tb_interleaver_seq;

  localparam int P = 4, FO = 2, Z = 2;
  localparam int LOG_P = 2, LPZ = 1, CPC = 4, CW = 2;
  localparam int PW = LOG_P * Z;
  localparam int EW = 1 + CW + PW;
  localparam logic [3:0] SEED_A = 4'b0110;
  localparam logic [3:0] SEED_B = 4'b0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]          reset_s, start_s, cont_s, ready_s;
  logic [1:0]          valid_s, last_s, busy_s;
  logic [1:0][PW-1:0]  pkg_s;
  logic [1:0][CW-1:0]  cyc_s;

`ifdef INTLV_SEED_LOAD_EN
  logic       ld_valid_b;
  logic       ld_row_b;
  logic [1:0] ld_data_b;
  logic       ld_ready_a, ld_ready_b;
`endif

  interleaver_seq #(.P(P), .FO(FO), .Z(Z), .SEED(SEED_A)) dut_a (
    .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .continuous(cont_s[0]),
    .out_valid(valid_s[0]), .out_ready(ready_s[0]), .mem_index_pkg(pkg_s[0]),
    .out_cycle(cyc_s[0]), .out_last(last_s[0]),
`ifdef INTLV_SEED_LOAD_EN
    .ld_valid(1'b0), .ld_row(1'b0), .ld_data(2'b00), .ld_ready(ld_ready_a),
`endif
    .busy(busy_s[0])
  );

  interleaver_seq #(.P(P), .FO(FO), .Z(Z), .SEED(SEED_B)) dut_b (
    .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .continuous(cont_s[1]),
    .out_valid(valid_s[1]), .out_ready(ready_s[1]), .mem_index_pkg(pkg_s[1]),
    .out_cycle(cyc_s[1]), .out_last(last_s[1]),
`ifdef INTLV_SEED_LOAD_EN
    .ld_valid(ld_valid_b), .ld_row(ld_row_b), .ld_data(ld_data_b), .ld_ready(ld_ready_b),
`endif
    .busy(busy_s[1])
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  logic [PW-1:0] got_q0[$];
  logic [PW-1:0] got_q1[$];
  int            acc_cnt[2];
  logic [1:0]    prev_stall;
  logic [EW-1:0] prev_out[2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference model straight from the address rules: wt, i, row, t, index.
  function automatic logic [PW-1:0] model_pkg(input logic [3:0] tab, input int c);
    logic [PW-1:0] r;
    int wt, i, row, chunk, t, idx;
    r = '0;
    for (int k = 0; k < Z; k++) begin
      wt    = c * Z + k;
      i     = wt % P;
      row   = c >> LPZ;
      chunk = (int'(tab) >> ((row * Z + (i % Z)) * LPZ)) & ((1 << LPZ) - 1);
      t     = (chunk + i / Z) % (P / Z);
      idx   = t * Z + (wt % Z);
      r[LOG_P*k +: LOG_P] = idx[LOG_P-1:0];
    end
    return r;
  endfunction

  task automatic push_pass(input int d, input logic [3:0] tab, input int n);
    logic [EW-1:0] e;
    int c;
    for (int j = 0; j < n; j++) begin
      c = j % CPC;
      e = {(c == CPC - 1) ? 1'b1 : 1'b0, c[CW-1:0], model_pkg(tab, c)};
      if (d == 0) exp_q0.push_back(e);
      else        exp_q1.push_back(e);
    end
  endtask

  // ---------------- compare process ----------------
  // Sampled on the falling edge; a package counts as accepted when valid and
  // ready are both high here (it transfers on the following rising edge).
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    logic [EW-1:0] e;
    int qsz;
    for (int d = 0; d < 2; d++) begin
      cur = {last_s[d], cyc_s[d], pkg_s[d]};
      if (reset_s[d]) begin
        prev_stall[d] = 1'b0;
      end else begin
        if (prev_stall[d]) check("stall_hold", {valid_s[d], cur}, {1'b1, prev_out[d]});
        if (valid_s[d]) check("last_flag", last_s[d], (cyc_s[d] == CPC - 1) ? 1 : 0);
        if (valid_s[d] && ready_s[d]) begin
          acc_cnt[d]++;
          if (d == 0) got_q0.push_back(pkg_s[d]);
          else        got_q1.push_back(pkg_s[d]);
          qsz = (d == 0) ? exp_q0.size() : exp_q1.size();
          if (qsz == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pkg: dut %0d got 0x%0h with nothing expected", d, cur);
          end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check("pkg_stream", cur, e);
          end
        end
        prev_stall[d] = valid_s[d] && !ready_s[d];
        prev_out[d]   = cur;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int d);
    int n;
    n = 0;
    while ((busy_s[d] || valid_s[d]) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) fail_now("wait_done");
  endtask

  // One non-continuous pass with out_ready held high; lit holds the four
  // hand-computed packages, cycle 0 in the low nibble.
  task automatic run_pass(input int d, input logic [3:0] tab, input logic [4*PW-1:0] lit);
    int n;
    if (d == 0) got_q0.delete();
    else        got_q1.delete();
    push_pass(d, tab, CPC);
    start_s[d] = 1'b1;
    tick();
    start_s[d] = 1'b0;
`ifdef INTLV_SEED_LOAD_EN
    // Keep offering a bogus row-0 write while running; it must be refused.
    if (d == 1 && ld_valid_b) begin
      ld_row_b  = 1'b0;
      ld_data_b = 2'b11;
    end
`endif
    check("start_busy", busy_s[d], 1);
    check("start_no_valid", valid_s[d], 0);
    tick();
    check("first_valid", valid_s[d], 1);
    check("first_cycle", cyc_s[d], 0);
    check("first_pkg", pkg_s[d], lit[PW-1:0]);
    n = 0;
    while (!(valid_s[d] && last_s[d]) && n < 20) begin
`ifdef INTLV_SEED_LOAD_EN
      if (d == 1) check("ld_ready_run", ld_ready_b, 0);
`endif
      tick();
      n++;
    end
    if (n >= 20) fail_now("pass_last");
`ifdef INTLV_SEED_LOAD_EN
    ld_valid_b = 1'b0;
`endif
    check("last_busy_low", busy_s[d], 0);
    check("last_valid_high", valid_s[d], 1);
    tick();
    check("drained", valid_s[d], 0);
    check("queue_empty", (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
    check("pkg_count", (d == 0) ? got_q0.size() : got_q1.size(), CPC);
    for (int j = 0; j < CPC; j++) begin
      if (d == 0 && j < got_q0.size()) check("lit_pkg", got_q0[j], lit[PW*j +: PW]);
      if (d == 1 && j < got_q1.size()) check("lit_pkg", got_q1[j], lit[PW*j +: PW]);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int base;
    reset_s = 2'b11;
    start_s = 2'b00;
    cont_s  = 2'b00;
    ready_s = 2'b11;
    acc_cnt[0] = 0;
    acc_cnt[1] = 0;
    prev_stall = 2'b00;
`ifdef INTLV_SEED_LOAD_EN
    ld_valid_b = 1'b0;
    ld_row_b   = 1'b0;
    ld_data_b  = 2'b00;
`endif
    repeat (3) tick();
    reset_s = 2'b00;

    // Reset values
    for (int d = 0; d < 2; d++) begin
      check("rst_valid", valid_s[d], 0);
      check("rst_busy", busy_s[d], 0);
      check("rst_pkg", pkg_s[d], 0);
      check("rst_cycle", cyc_s[d], 0);
      check("rst_last", last_s[d], 0);
    end
`ifdef INTLV_SEED_LOAD_EN
    check("rst_ld_ready_a", ld_ready_a, 1);
    check("rst_ld_ready_b", ld_ready_b, 1);
`endif

    // Basic passes: SEED 0110 and SEED 0
    run_pass(0, SEED_A, 16'hC66C);
    run_pass(1, SEED_B, 16'hE4E4);

    // Backpressure on the second package
    got_q0.delete();
    push_pass(0, SEED_A, CPC);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    n = 0;
    while (!(valid_s[0] && cyc_s[0] == 1) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) fail_now("bp_reach_cycle1");
    ready_s[0] = 1'b0;
    repeat (3) begin
      tick();
      check("bp_valid", valid_s[0], 1);
      check("bp_pkg", pkg_s[0], 4'h6);
      check("bp_cycle", cyc_s[0], 1);
    end
    ready_s[0] = 1'b1;
    wait_done(0);
    check("bp_queue_empty", exp_q0.size(), 0);
    check("bp_count", got_q0.size(), CPC);
    if (got_q0.size() == CPC) begin
      check("bp_pkg0", got_q0[0], 4'hC);
      check("bp_pkg1", got_q0[1], 4'h6);
      check("bp_pkg2", got_q0[2], 4'h6);
      check("bp_pkg3", got_q0[3], 4'hC);
    end

    // Continuous: 10 accepted packages, then drop continuous
    base = acc_cnt[0];
    push_pass(0, SEED_A, 3 * CPC);
    cont_s[0]  = 1'b1;
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    n = 0;
    while (acc_cnt[0] - base < 10 && n < 100) begin
      tick();
      n++;
      check("cont_busy", busy_s[0], 1);
    end
    if (n >= 100) fail_now("cont_ten");
    cont_s[0] = 1'b0;
    wait_done(0);
    check("cont_total", acc_cnt[0] - base, 3 * CPC);
    check("cont_queue_empty", exp_q0.size(), 0);

    // Reset in the middle of a pass
    push_pass(0, SEED_A, CPC);
    start_s[0] = 1'b1;
    tick();
    start_s[0] = 1'b0;
    n = 0;
    while (!(valid_s[0] && cyc_s[0] == 2) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) fail_now("mid_reach_cycle2");
    reset_s[0] = 1'b1;
    tick();
    reset_s[0] = 1'b0;
    check("mid_rst_valid", valid_s[0], 0);
    check("mid_rst_busy", busy_s[0], 0);
    check("mid_rst_cycle", cyc_s[0], 0);
    check("mid_rst_pkg", pkg_s[0], 0);
    check("mid_rst_last", last_s[0], 0);
    exp_q0.delete();
    tick();
    run_pass(0, SEED_A, 16'hC66C);

`ifdef INTLV_SEED_LOAD_EN
    // Load row 1 together with start; pass uses the new row
    ld_valid_b = 1'b1;
    ld_row_b   = 1'b1;
    ld_data_b  = 2'b01;
    run_pass(1, 4'b0100, 16'hC6E4);
    // Bogus write offered during RUN must not have landed
    run_pass(1, 4'b0100, 16'hC6E4);
    ld_valid_b = 1'b1;
    ld_row_b   = 1'b1;
    ld_data_b  = 2'b10;
    run_pass(1, 4'b1000, 16'h6CE4);
    // Reset restores SEED
    reset_s[1] = 1'b1;
    tick();
    reset_s[1] = 1'b0;
    check("ld_rst_ready", ld_ready_b, 1);
    run_pass(1, SEED_B, 16'hE4E4);
`endif

    repeat (2) tick();
    check("final_q0_empty", exp_q0.size(), 0);
    check("final_q1_empty", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
